div_iter: RTL
=============

# div_iter

Iterative 32-bit radix-2 restoring divider for the execute stage, sitting directly downstream of the main decoder. When the decoder flags DIV/DIVU, i.e. it asserts hi/lo write-back with gprtohi=gprtolo=1, execute raises `start`. The block computes quotient and remainder over 32 cycles while holding `stall` to freeze the pipeline. It then presents {remainder, quotient} for one cycle, for writing into the HI/LO registers.

## Interface
- `WIDTH`, 32, operand width. Iteration count equals WIDTH.
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: divide request from execute, level-held while stalled.
- `signed_div` in 1: 1 = DIV, 0 = DIVU. Sampled with `start`.
- `annul` in 1: flush/exception cancel of the in-flight divide.
- `opa` in WIDTH: dividend (rs value).
- `opb` in WIDTH: divisor (rt value).
- `stall` out 1: pipeline freeze request.
- `valid` out 1: result-valid strobe, 1 cycle.
- `result` out 2*WIDTH: {hi=remainder, lo=quotient}. Meaningful only when `valid`=1.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - On `start`=1 and `annul`=0, latch operands and `signed_div`.
  - If `signed_div`, latch magnitudes |opa| and |opb|, plus qneg = opa[31]^opb[31] and rneg = opa[31].
  - If `opb`==0, go to DONE. Otherwise go to BUSY with count=0.
- BUSY, one iteration per cycle:
  - Shift {rem, dividend} left 1.
  - trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem=trial and the quotient bit is 1; else the quotient bit is 0.
  - count increments each cycle. After count==WIDTH-1 completes, go to DONE.
- DONE:
  - `valid`=1 for exactly this cycle, then go to IDLE.
  - Signed: quotient = qneg ? -q : q, remainder = rneg ? -r : r, both two's complement modulo 2^WIDTH.
  - Divide by zero (both signednesses): quotient = 32'hFFFFFFFF, remainder = opa as latched (raw, not the magnitude).
- `stall` is combinational: 1 when (IDLE && `start` && !`annul`) or BUSY; 0 in DONE, so the pipeline advances on the `valid` cycle.
- `start` in BUSY or DONE is ignored; the operands latched in IDLE are the ones used.
- `annul`=1 in BUSY or DONE: go to IDLE on the next edge, `valid` stays 0, and `stall` drops in the same cycle (combinational).
- `annul` has priority over iteration and completion.
- `result` holds its last value when not valid. Consumers must qualify it with `valid`.

## Timing
- Reset, when `resetn` is sampled 0, gives:
  - state=IDLE, count=0, internal rem/quotient registers = 0.
  - `valid`=0, `result`=0.
  - `stall`=0 unless `start` is asserted in that cycle.
- Reset mid-BUSY aborts the divide; no `valid` follows.
- Normal latency: `start` accepted at cycle T, BUSY during T+1..T+32, `valid` at T+33. `stall` is 1 during T..T+32 and 0 at T+33.
- Divide by zero: accepted at T, `valid` at T+1, `stall` 1 only at T.
- Back-to-back: a new `start` is accepted at the earliest in the IDLE cycle after DONE (T+34).
- Throughput: one divide per 34 cycles.

## Test plan
- DIVU 100/7: `start` at T, opa=100, opb=7 → `valid` at T+33 with `result`={32'd2, 32'd14}; `stall` high during T..T+32.
- DIV -7/2: opa=32'hFFFFFFF9, opb=2, signed → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV overflow: opa=32'h80000000, opb=32'hFFFFFFFF, signed → lo=32'h80000000, hi=0. DIVU of the same operands → lo=0, hi=32'h80000000.
- Divide by zero: opa=32'h12345678, opb=0 → `valid` at T+1, lo=32'hFFFFFFFF, hi=32'h12345678.
- Annul: start 100/7, pulse `annul` at T+10 → state IDLE at T+11, `stall` 0 from T+10, no `valid` through T+40. A new start 9/3 at T+12 → `valid` at T+45 with lo=3, hi=0.
- Reset mid-op: drive `resetn`=0 at T+5 for one cycle → `valid`=0, `result`=0, `stall`=0 with `start` low, no completion afterward.

Source files
------------

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the execute stage.
// One quotient bit per cycle; the {remainder, quotient} result feeds the HI/LO registers.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    output logic                 stall,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     divisor;
    logic                 qneg;
    logic                 rneg;
    logic [2*WIDTH-1:0]   result_q;

    logic                 accept;
    logic                 last_iter;
    logic [WIDTH-1:0]     opa_mag;
    logic [WIDTH-1:0]     opb_mag;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     rem_n;
    logic [WIDTH-1:0]     quo_n;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     quo_fix;

    // Handshake: a request is taken when start=1 and annul=0 in IDLE; stall stays high
    // until the result cycle, where valid=1 for exactly one cycle and stall=0.
    assign accept    = (state == S_IDLE) && start && !annul;
    assign last_iter = (count == CW'(WIDTH - 1));

    always_comb begin
        opa_mag = opa;
        opb_mag = opb;
        if (signed_div && opa[WIDTH-1]) opa_mag = -opa;
        if (signed_div && opb[WIDTH-1]) opb_mag = -opb;
    end

    // The dividend lives in quo and is shifted out MSB-first into the partial remainder.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_n = trial[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = rem_shift[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
        quo_fix = qneg ? -quo_n : quo_n;
        rem_fix = rneg ? -rem_n : rem_n;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        valid      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = (opb == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (annul) begin
                    state_next = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (last_iter) state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                valid      = !annul;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count   <= '0;
                        rem     <= '0;
                        quo     <= opa_mag;
                        divisor <= opb_mag;
                        qneg    <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        rneg    <= signed_div & opa[WIDTH-1];
                        // Divide by zero reports the raw dividend as remainder.
                        if (opb == '0) result_q <= {opa, {WIDTH{1'b1}}};
                    end
                end
                S_BUSY: begin
                    if (!annul) begin
                        rem   <= rem_n;
                        quo   <= quo_n;
                        count <= count + 1'b1;
                        if (last_iter) result_q <= {rem_fix, quo_fix};
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign dbg_state = state;

endmodule
